// File: rtl/idct_2d.sv
// 8x8 two-dimensional inverse DCT: row pass into a transpose buffer, then column pass.
// Optional macro PINGPONG_EN selects two buffers so loading overlaps the column pass.
module idct_2d #(
  parameter int unsigned DW = 12,
  parameter int unsigned CW = 9,
  parameter int unsigned AW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in0,
  input  logic signed [DW-1:0] in1,
  input  logic signed [DW-1:0] in2,
  input  logic signed [DW-1:0] in3,
  input  logic signed [DW-1:0] in4,
  input  logic signed [DW-1:0] in5,
  input  logic signed [DW-1:0] in6,
  input  logic signed [DW-1:0] in7,
  output logic                 out_en,
  output logic signed [DW-1:0] out0,
  output logic signed [DW-1:0] out1,
  output logic signed [DW-1:0] out2,
  output logic signed [DW-1:0] out3,
  output logic signed [DW-1:0] out4,
  output logic signed [DW-1:0] out5,
  output logic signed [DW-1:0] out6,
  output logic signed [DW-1:0] out7
);

  localparam int Lim = 1 << (DW - 1);
  localparam logic signed [AW-1:0] SatHi = AW'(Lim - 1);
  localparam logic signed [AW-1:0] SatLo = AW'(-Lim);

  // Basis for n = 0..3; n = 4..7 mirrors it, negated for odd k.
  localparam int Rom [8][4] = '{
    '{ 91,   91,   91,   91},
    '{126,  106,   71,   25},
    '{118,   49,  -49, -118},
    '{106,  -25, -126,  -71},
    '{ 91,  -91,  -91,   91},
    '{ 71, -126,   25,  106},
    '{ 49, -118,  118,  -49},
    '{ 25,  -71,  106, -126}
  };

  function automatic logic [8*DW-1:0] idct1d(input logic [8*DW-1:0] x);
    logic [8*DW-1:0]      y;
    logic signed [CW-1:0] c;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] prod;
    logic signed [AW-1:0] res;
    int                   m;
    int                   v;
    y = '0;
    for (int n = 0; n < 8; n++) begin
      acc = '0;
      m   = (n < 4) ? n : 7 - n;
      for (int k = 0; k < 8; k++) begin
        v = Rom[k][m];
        if ((n >= 4) && ((k % 2) == 1)) v = -v;
        c    = CW'(v);
        prod = AW'(c) * AW'($signed(x[k*DW +: DW]));
        acc  = acc + prod;
      end
      res = (acc + AW'(128)) >>> 8;
      if (res > SatHi) res = SatHi;
      else if (res < SatLo) res = SatLo;
      y[n*DW +: DW] = res[DW-1:0];
    end
    return y;
  endfunction

  logic [8*DW-1:0] w_row_vec;
  logic [8*DW-1:0] w_col_vec;
  logic [8*DW-1:0] r_out;
  logic            r_out_en;
  logic            w_accept;

  assign w_row_vec = {in7, in6, in5, in4, in3, in2, in1, in0};

`ifdef PINGPONG_EN
  logic [DW-1:0]   r_buf [128];
  logic            r_wbank, r_rbank, r_rd_act, r_pend;
  logic [2:0]      r_wcnt, r_rcnt;
  logic            w_wr_done, w_rd_last;
  logic [8*DW-1:0] w_row_res, w_col_res;

  assign in_ready  = ~rst & ~r_pend;
  assign w_accept  = in_valid & in_ready;
  assign w_wr_done = w_accept & (r_wcnt == 3'd7);
  assign w_rd_last = r_rd_act & (r_rcnt == 3'd7);
  assign w_row_res = idct1d(w_row_vec);
  assign w_col_res = idct1d(w_col_vec);

  always_comb begin
    w_col_vec = '0;
    for (int j = 0; j < 8; j++) w_col_vec[j*DW +: DW] = r_buf[{r_rbank, 3'(j), r_rcnt}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbank  <= 1'b0;
      r_rbank  <= 1'b0;
      r_rd_act <= 1'b0;
      r_pend   <= 1'b0;
      r_wcnt   <= 3'd0;
      r_rcnt   <= 3'd0;
    end else begin
      if (w_accept) r_wcnt <= r_wcnt + 3'd1;
      if (w_wr_done) r_wbank <= ~r_wbank;
      if (r_rd_act) r_rcnt <= r_rcnt + 3'd1;
      if (w_wr_done && (!r_rd_act || w_rd_last)) begin
        r_rd_act <= 1'b1;
        r_rbank  <= r_wbank;
        r_rcnt   <= 3'd0;
      end else if (w_wr_done) begin
        // Both buffers full: hold input until the running column pass ends.
        r_pend <= 1'b1;
      end else if (r_pend && w_rd_last) begin
        r_pend   <= 1'b0;
        r_rbank  <= ~r_rbank;
        r_rcnt   <= 3'd0;
      end else if (w_rd_last) begin
        r_rd_act <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int j = 0; j < 8; j++) r_buf[{r_wbank, r_wcnt, 3'(j)}] <= w_row_res[j*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_en <= 1'b0;
      r_out    <= '0;
    end else begin
      r_out_en <= r_rd_act;
      if (r_rd_act) r_out <= w_col_res;
    end
  end
`else
  typedef enum logic {StLoad, StCol} state_e;

  state_e          r_state, w_state_nxt;
  logic [2:0]      r_cnt, w_cnt_nxt;
  logic [DW-1:0]   r_buf [64];
  logic [8*DW-1:0] w_dp_out;

  assign in_ready = ~rst & (r_state == StLoad);
  assign w_accept = in_valid & in_ready;
  // One datapath serves both passes since they never overlap.
  assign w_dp_out = idct1d((r_state == StCol) ? w_col_vec : w_row_vec);

  always_comb begin
    w_col_vec = '0;
    for (int j = 0; j < 8; j++) w_col_vec[j*DW +: DW] = r_buf[{3'(j), r_cnt}];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StLoad: begin
        if (w_accept) begin
          w_cnt_nxt = r_cnt + 3'd1;
          if (r_cnt == 3'd7) w_state_nxt = StCol;
        end
      end
      StCol: begin
        w_cnt_nxt = r_cnt + 3'd1;
        if (r_cnt == 3'd7) w_state_nxt = StLoad;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StLoad;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int j = 0; j < 8; j++) r_buf[{r_cnt, 3'(j)}] <= w_dp_out[j*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_en <= 1'b0;
      r_out    <= '0;
    end else begin
      r_out_en <= (r_state == StCol);
      if (r_state == StCol) r_out <= w_dp_out;
    end
  end
`endif

  assign out_en = r_out_en;
  assign out0   = r_out[0*DW +: DW];
  assign out1   = r_out[1*DW +: DW];
  assign out2   = r_out[2*DW +: DW];
  assign out3   = r_out[3*DW +: DW];
  assign out4   = r_out[4*DW +: DW];
  assign out5   = r_out[5*DW +: DW];
  assign out6   = r_out[6*DW +: DW];
  assign out7   = r_out[7*DW +: DW];

endmodule

// File: tb/tb_idct_2d.sv
// Directed and model-based bench for idct_2d; block spacing depends on PINGPONG_EN.
module tb_idct_2d;
  localparam int DW = 12;
`ifdef PINGPONG_EN
  localparam int Spacing = 8;
`else
  localparam int Spacing = 16;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic                 out_en;
  logic signed [DW-1:0] in_v  [8];
  logic signed [DW-1:0] out_v [8];

  idct_2d dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
    .in4(in_v[4]), .in5(in_v[5]), .in6(in_v[6]), .in7(in_v[7]),
    .out_en(out_en),
    .out0(out_v[0]), .out1(out_v[1]), .out2(out_v[2]), .out3(out_v[3]),
    .out4(out_v[4]), .out5(out_v[5]), .out6(out_v[6]), .out7(out_v[7])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int A      [8][8];
  int blk_x  [8][8];
  int exp_y  [8][8];
  int bx_all [4][8][8];
  int ey_all [4][8][8];
  logic [8*DW-1:0] cap_q[$];
  int              cap_cyc[$];
  logic            rdy_hist [9];

  always @(negedge clk) begin
    if (out_en === 1'b1) begin
      cap_q.push_back({out_v[7], out_v[6], out_v[5], out_v[4],
                       out_v[3], out_v[2], out_v[1], out_v[0]});
      cap_cyc.push_back(cyc);
    end
  end

  function automatic int sat12(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic int cap_val(input int c, input int n);
    logic [8*DW-1:0]      w;
    logic signed [DW-1:0] s;
    w = cap_q[c];
    s = w[n*DW +: DW];
    return int'(s);
  endfunction

  // Basis derived from the cosine definition, independent of any table.
  task automatic build_basis();
    real c, v;
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 8; n++) begin
        c = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        v = 128.0 * c * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
        A[k][n] = $rtoi(v + ((v >= 0.0) ? 0.5 : -0.5));
      end
    end
  endtask

  task automatic model();
    int t [8][8];
    int s;
    for (int r = 0; r < 8; r++) begin
      for (int n = 0; n < 8; n++) begin
        s = 0;
        for (int k = 0; k < 8; k++) s += A[k][n] * blk_x[r][k];
        t[r][n] = sat12((s + 128) >>> 8);
      end
    end
    for (int c = 0; c < 8; c++) begin
      for (int n = 0; n < 8; n++) begin
        s = 0;
        for (int k = 0; k < 8; k++) s += A[k][n] * t[k][c];
        exp_y[n][c] = sat12((s + 128) >>> 8);
      end
    end
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        if (mode == 0) blk_x[r][k] = 0;
        else if (mode == 1) blk_x[r][k] = int'($urandom_range(128)) - 64;
        else blk_x[r][k] = int'($urandom_range(4095)) - 2048;
      end
    end
  endtask

  task automatic run_block(input bit gaps, input bit hold, output int last_drv);
    int r;
    int guard;
    cap_q.delete();
    cap_cyc.delete();
    r        = 0;
    guard    = 0;
    last_drv = -100;
    while (r < 8 && guard < 200) begin
      @(negedge clk);
      in_valid = gaps ? 1'($urandom_range(1)) : 1'b1;
      for (int k = 0; k < 8; k++) in_v[k] = DW'(blk_x[r][k]);
      if (in_valid && in_ready) begin
        last_drv = cyc;
        r++;
      end
      guard++;
    end
    if (hold) begin
      for (int h = 0; h < 8; h++) begin
        @(negedge clk);
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) in_v[k] = 12'sh5A5;
        rdy_hist[h] = in_ready;
      end
    end
    @(negedge clk);
    in_valid    = 1'b0;
    rdy_hist[8] = in_ready;
    guard       = 0;
    while (cap_q.size() < 8 && guard < 60) begin
      @(negedge clk);
      #1;
      guard++;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) in_v[k] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %b want 0", in_ready);
    end
    checks++;
    if (out_en !== 1'b0) begin
      errors++; $display("FAIL reset_out_en got %b want 0", out_en);
    end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (out_v[n] !== 12'sd0) begin
        errors++; $display("FAIL reset_out%0d got %0d want 0", n, out_v[n]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_dc();
    int ld;
    fill(0);
    blk_x[0][0] = 64;
    run_block(1'b0, 1'b0, ld);
    checks++;
    if (cap_q.size() != 8) begin
      errors++; $display("FAIL dc_count got %0d want 8", cap_q.size());
    end else begin
      checks++;
      if (cap_cyc[0] != ld + 2) begin
        errors++; $display("FAIL dc_latency got %0d want %0d", cap_cyc[0], ld + 2);
      end
      checks++;
      if (cap_cyc[7] != cap_cyc[0] + 7) begin
        errors++; $display("FAIL dc_contiguous got %0d want %0d", cap_cyc[7], cap_cyc[0] + 7);
      end
      // 91*64 -> 23 after the row pass, 91*23 -> 8 after the column pass.
      for (int c = 0; c < 8; c++) begin
        for (int n = 0; n < 8; n++) begin
          checks++;
          if (cap_val(c, n) != 8) begin
            errors++; $display("FAIL dc[%0d][%0d] got %0d want 8", n, c, cap_val(c, n));
          end
        end
      end
    end
    checks++;
    if (out_en !== 1'b0) begin
      errors++; $display("FAIL dc_out_en_drop got %b want 0", out_en);
    end
  endtask

  task automatic test_zero();
    int ld;
    fill(0);
    run_block(1'b0, 1'b0, ld);
    checks++;
    if (cap_q.size() != 8) begin
      errors++; $display("FAIL zero_count got %0d want 8", cap_q.size());
    end else begin
      checks++;
      if (cap_cyc[0] != ld + 2) begin
        errors++; $display("FAIL zero_latency got %0d want %0d", cap_cyc[0], ld + 2);
      end
      for (int c = 0; c < 8; c++) begin
        for (int n = 0; n < 8; n++) begin
          checks++;
          if (cap_val(c, n) != 0) begin
            errors++; $display("FAIL zero[%0d][%0d] got %0d want 0", n, c, cap_val(c, n));
          end
        end
      end
    end
  endtask

  task automatic test_saturation();
    int ld;
    fill(0);
    blk_x[0][0] = 2047;
    run_block(1'b0, 1'b0, ld);
    checks++;
    if (cap_q.size() != 8) begin
      errors++; $display("FAIL sat1_count got %0d want 8", cap_q.size());
    end else begin
      // 91*2047 -> 728 after the row pass, 91*728 -> 259 after the column pass.
      for (int c = 0; c < 8; c++) begin
        for (int n = 0; n < 8; n++) begin
          checks++;
          if (cap_val(c, n) != 259) begin
            errors++; $display("FAIL sat1[%0d][%0d] got %0d want 259", n, c, cap_val(c, n));
          end
        end
      end
    end
    for (int r = 0; r < 8; r++) for (int k = 0; k < 8; k++) blk_x[r][k] = 2047;
    model();
    run_block(1'b0, 1'b0, ld);
    checks++;
    if (cap_q.size() != 8) begin
      errors++; $display("FAIL satall_count got %0d want 8", cap_q.size());
    end else begin
      checks++;
      if (cap_val(0, 0) != 2047) begin
        errors++; $display("FAIL satall_clamp_hi got %0d want 2047", cap_val(0, 0));
      end
      checks++;
      if (cap_val(0, 1) != -1479) begin
        errors++; $display("FAIL satall_y10 got %0d want -1479", cap_val(0, 1));
      end
      checks++;
      if (cap_val(1, 0) != -2048) begin
        errors++; $display("FAIL satall_clamp_lo got %0d want -2048", cap_val(1, 0));
      end
      for (int c = 0; c < 8; c++) begin
        for (int n = 0; n < 8; n++) begin
          checks++;
          if (cap_val(c, n) != exp_y[n][c]) begin
            errors++;
            $display("FAIL satall[%0d][%0d] got %0d want %0d", n, c, cap_val(c, n), exp_y[n][c]);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    int ld;
    bit hold;
`ifdef PINGPONG_EN
    hold = 1'b0;
`else
    hold = 1'b1;
`endif
    fill(2);
    model();
    run_block(1'b1, hold, ld);
    checks++;
    if (cap_q.size() != 8) begin
      errors++; $display("FAIL stall_count got %0d want 8", cap_q.size());
    end else begin
      for (int c = 0; c < 8; c++) begin
        for (int n = 0; n < 8; n++) begin
          checks++;
          if (cap_val(c, n) != exp_y[n][c]) begin
            errors++;
            $display("FAIL stall[%0d][%0d] got %0d want %0d", n, c, cap_val(c, n), exp_y[n][c]);
          end
        end
      end
    end
    if (hold) begin
      for (int h = 0; h < 8; h++) begin
        checks++;
        if (rdy_hist[h] !== 1'b0) begin
          errors++; $display("FAIL stall_ready_col%0d got %b want 0", h, rdy_hist[h]);
        end
      end
    end
    checks++;
    if (rdy_hist[8] !== 1'b1) begin
      errors++; $display("FAIL stall_ready_after got %b want 1", rdy_hist[8]);
    end
  endtask

  task automatic test_reset_mid();
    int ld;
    int r;
    int guard;
    fill(2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) in_v[k] = DW'(blk_x[i][k]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cap_q.delete();
    cap_cyc.delete();
    r     = 0;
    guard = 0;
    while (r < 8 && guard < 100) begin
      @(negedge clk);
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) in_v[k] = DW'(blk_x[r][k]);
      if (in_ready) r++;
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    guard    = 0;
    while (cap_q.size() < 3 && guard < 40) begin
      @(negedge clk);
      #1;
      guard++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cap_q.size() != 3) begin
      errors++; $display("FAIL midcol_cols got %0d want 3", cap_q.size());
    end
    checks++;
    if (out_en !== 1'b0) begin
      errors++; $display("FAIL midcol_out_en got %b want 0", out_en);
    end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (out_v[n] !== 12'sd0) begin
        errors++; $display("FAIL midcol_out%0d got %0d want 0", n, out_v[n]);
      end
    end
    rst = 1'b0;
    fill(1);
    model();
    run_block(1'b0, 1'b0, ld);
    checks++;
    if (cap_q.size() != 8) begin
      errors++; $display("FAIL after_reset_count got %0d want 8", cap_q.size());
    end else begin
      for (int c = 0; c < 8; c++) begin
        for (int n = 0; n < 8; n++) begin
          checks++;
          if (cap_val(c, n) != exp_y[n][c]) begin
            errors++;
            $display("FAIL after_reset[%0d][%0d] got %0d want %0d",
                     n, c, cap_val(c, n), exp_y[n][c]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int ld;
    for (int b = 0; b < 100; b++) begin
      fill((b % 2 == 0) ? 1 : 2);
      model();
      run_block(1'b0, 1'b0, ld);
      checks++;
      if (cap_q.size() != 8) begin
        errors++; $display("FAIL rand%0d_count got %0d want 8", b, cap_q.size());
      end else begin
        for (int c = 0; c < 8; c++) begin
          for (int n = 0; n < 8; n++) begin
            checks++;
            if (cap_val(c, n) != exp_y[n][c]) begin
              errors++;
              $display("FAIL rand%0d[%0d][%0d] got %0d want %0d",
                       b, n, c, cap_val(c, n), exp_y[n][c]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int  idx;
    int  guard;
    bit  rdy_drop;
    for (int b = 0; b < 4; b++) begin
      fill(2);
      model();
      bx_all[b] = blk_x;
      ey_all[b] = exp_y;
    end
    cap_q.delete();
    cap_cyc.delete();
    idx      = 0;
    guard    = 0;
    rdy_drop = 1'b0;
    while (idx < 32 && guard < 400) begin
      @(negedge clk);
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) in_v[k] = DW'(bx_all[idx / 8][idx % 8][k]);
      if (in_ready) idx++;
      else rdy_drop = 1'b1;
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    guard    = 0;
    while (cap_q.size() < 32 && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checks++;
    if (cap_q.size() != 32) begin
      errors++; $display("FAIL b2b_count got %0d want 32", cap_q.size());
    end else begin
      for (int b = 1; b < 4; b++) begin
        checks++;
        if (cap_cyc[8*b] - cap_cyc[8*b-8] != Spacing) begin
          errors++;
          $display("FAIL b2b_spacing%0d got %0d want %0d", b,
                   cap_cyc[8*b] - cap_cyc[8*b-8], Spacing);
        end
      end
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 8; c++) begin
          for (int n = 0; n < 8; n++) begin
            checks++;
            if (cap_val(8*b + c, n) != ey_all[b][n][c]) begin
              errors++;
              $display("FAIL b2b%0d[%0d][%0d] got %0d want %0d",
                       b, n, c, cap_val(8*b + c, n), ey_all[b][n][c]);
            end
          end
        end
      end
    end
`ifdef PINGPONG_EN
    checks++;
    if (rdy_drop) begin
      errors++; $display("FAIL b2b_ready_drop got 1 want 0");
    end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    build_basis();
    test_reset();
    test_dc();
    test_zero();
    test_saturation();
    test_stall();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
